// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared phase encodings and light codes for the intersection sequencer
package traffic_pkg;

  typedef enum logic [2:0] {
    MAIN_G   = 3'd0,
    MAIN_Y   = 3'd1,
    ALLRED_A = 3'd2,
    SIDE_G   = 3'd3,
    SIDE_Y   = 3'd4,
    ALLRED_B = 3'd5
  } phase_e;

  localparam logic [1:0] LT_RED = 2'b00;
  localparam logic [1:0] LT_YEL = 2'b01;
  localparam logic [1:0] LT_GRN = 2'b10;

  function automatic logic [1:0] main_light(input phase_e p);
    case (p)
      MAIN_G:  return LT_GRN;
      MAIN_Y:  return LT_YEL;
      default: return LT_RED;
    endcase
  endfunction

  function automatic logic [1:0] side_light(input phase_e p);
    case (p)
      SIDE_G:  return LT_GRN;
      SIDE_Y:  return LT_YEL;
      default: return LT_RED;
    endcase
  endfunction

endpackage

// File: rtl/phase_timer.sv
// rtl/phase_timer.sv - down-counter that loads a phase duration and parks at zero
module phase_timer #(
  parameter int             TW      = 4,
  parameter logic [TW-1:0]  RST_VAL = '0
) (
  input  logic          CK,
  input  logic          RST,
  input  logic          EN,
  input  logic          LOAD,
  input  logic [TW-1:0] LVAL,
  output logic [TW-1:0] CNT,
  output logic          ZERO
);

  logic [TW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (LOAD) begin
      cnt_d = LVAL;
    end else if (EN && (cnt_q != '0)) begin
      cnt_d = cnt_q - TW'(1);
    end
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      cnt_q <= RST_VAL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign CNT  = cnt_q;
  assign ZERO = (cnt_q == '0);

endmodule

// File: rtl/traffic_phase_ctrl.sv
// rtl/traffic_phase_ctrl.sv - two-road phase sequencer with car sensing and pedestrian handshake
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int GREEN_CYC  = 12,
  parameter int YELLOW_CYC = 3,
  parameter int ALLRED_CYC = 2,
  parameter int MIN_GREEN  = 4,
  parameter int TW         = 4
) (
  input  logic          CK,
  input  logic          RST,
  input  logic          EN,
  input  logic          CAR_B,
  input  logic          PED_REQ,
  output logic          PED_ACK,
  output logic [1:0]    MAIN_LIGHT,
  output logic [1:0]    SIDE_LIGHT,
  output logic          WALK,
  output logic [2:0]    PHASE,
  output logic [TW-1:0] TMR
);

  function automatic logic [TW-1:0] dur_m1(input phase_e p);
    case (p)
      MAIN_Y, SIDE_Y:     return TW'(YELLOW_CYC - 1);
      ALLRED_A, ALLRED_B: return TW'(ALLRED_CYC - 1);
      SIDE_G:             return TW'(GREEN_CYC - 1);
      default:            return TW'(MIN_GREEN - 1);
    endcase
  endfunction

  phase_e        phase_q, phase_d;
  logic          req_q;
  logic          pend_q, pend_d;
  logic          srv_q, srv_d;
  logic          ack_q, ack_d;
  logic          walk_q, walk_d;
  logic [1:0]    main_q, side_q;
  logic          tmr_zero;
  logic          tmr_load;
  logic [TW-1:0] tmr_lval;
  logic          enter_side;

  phase_timer #(
    .TW      (TW),
    .RST_VAL (TW'(MIN_GREEN - 1))
  ) u_timer (
    .CK   (CK),
    .RST  (RST),
    .EN   (EN),
    .LOAD (tmr_load),
    .LVAL (tmr_lval),
    .CNT  (TMR),
    .ZERO (tmr_zero)
  );

  always_comb begin
    phase_d = phase_q;
    case (phase_q)
      MAIN_G:   if (EN && tmr_zero && (CAR_B || pend_q)) phase_d = MAIN_Y;
      MAIN_Y:   if (EN && tmr_zero) phase_d = ALLRED_A;
      ALLRED_A: if (EN && tmr_zero) phase_d = SIDE_G;
      SIDE_G:   if (EN && tmr_zero) phase_d = SIDE_Y;
      SIDE_Y:   if (EN && tmr_zero) phase_d = ALLRED_B;
      ALLRED_B: if (EN && tmr_zero) phase_d = MAIN_G;
      default:  phase_d = MAIN_G;
    endcase
    tmr_load = (phase_d != phase_q);
    tmr_lval = dur_m1(phase_d);

    // A new request latched on the entry edge itself waits for the next side phase.
    enter_side = (phase_d == SIDE_G) && (phase_q != SIDE_G);
    ack_d      = enter_side && pend_q;
    pend_d     = (PED_REQ && !req_q) || (pend_q && !ack_d);
    srv_d      = ack_d ? 1'b1 : ((phase_d == SIDE_G) ? srv_q : 1'b0);
    walk_d     = srv_d && (phase_d == SIDE_G);
  end

  always_ff @(posedge CK) begin
    req_q <= PED_REQ;
    if (RST) begin
      phase_q <= MAIN_G;
      pend_q  <= 1'b0;
      srv_q   <= 1'b0;
      ack_q   <= 1'b0;
      walk_q  <= 1'b0;
      main_q  <= LT_GRN;
      side_q  <= LT_RED;
    end else begin
      phase_q <= phase_d;
      pend_q  <= pend_d;
      srv_q   <= srv_d;
      ack_q   <= ack_d;
      walk_q  <= walk_d;
      main_q  <= main_light(phase_d);
      side_q  <= side_light(phase_d);
    end
  end

  assign PHASE      = phase_q;
  assign PED_ACK    = ack_q;
  assign WALK       = walk_q;
  assign MAIN_LIGHT = main_q;
  assign SIDE_LIGHT = side_q;

endmodule
